// File: rtl/mul_arb_pkg.sv
// Shared types, defaults and round-robin helper for the
// multiplier arbiter and its iterative multiplier.
package mul_arb_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_N_REQ = 4;
    localparam int MAX_REQ   = 8;
    localparam int IDX_W     = 3;
    localparam int SUM_W     = IDX_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_ADD  = 2'd1,
        MS_FIN  = 2'd2
    } mul_state_t;

    // First set request at ptr+1, ptr+2, ... wrapping modulo n.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [IDX_W-1:0]   ptr,
        input int                 n
    );
        logic [SUM_W-1:0] s;
        logic             found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            s = {1'b0, ptr} + SUM_W'(k);
            if (s >= SUM_W'(n))
                s = s - SUM_W'(n);
            if (!found && k <= n && req[s[IDX_W-1:0]]) begin
                rr_pick = s[IDX_W-1:0];
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/mul_arbiter_mul_iter.sv
// Repeated-addition multiplier: b additions of a, then a
// one-cycle done pulse. b=0 reports done at the start edge.
module mul_iter
    import mul_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] r,
    output logic             done
);

    mul_state_t       r_state;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_cnt;
    logic             r_done;

    // Accumulate a once per cycle until b additions are made.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= MS_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                MS_IDLE: begin
                    if (start) begin
                        if (b == '0) begin
                            r_acc  <= '0;
                            r_done <= 1'b1;
                        end else begin
                            r_acc   <= a;
                            r_cnt   <= b - WIDTH'(1);
                            r_state <= (b == WIDTH'(1)) ? MS_FIN : MS_ADD;
                        end
                    end
                end
                MS_ADD: begin
                    r_acc <= r_acc + a;
                    r_cnt <= r_cnt - WIDTH'(1);
                    if (r_cnt == WIDTH'(1))
                        r_state <= MS_FIN;
                end
                MS_FIN: begin
                    r_done  <= 1'b1;
                    r_state <= MS_IDLE;
                end
                default: r_state <= MS_IDLE;
            endcase
        end
    end

    assign r    = r_acc;
    assign done = r_done;

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one iterative multiplier
// among N_REQ level-request / pulse-acknowledge clients.
module mul_arbiter
    import mul_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*WIDTH-1:0] a_in,
    input  logic [N_REQ*WIDTH-1:0] b_in,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   ack,
    output logic [WIDTH-1:0]   result,
    output logic               busy
);

    arb_state_t       r_state;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_win;
    logic [N_REQ-1:0] r_gnt;
    logic [N_REQ-1:0] r_ack;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_start;

    logic [MAX_REQ-1:0] w_req8;
    logic [IDX_W-1:0]   w_pick;
    logic [WIDTH-1:0]   w_mul_r;
    logic               w_mul_done;

    // Widen the request vector to the helper's fixed width.
    always_comb begin
        w_req8             = '0;
        w_req8[N_REQ-1:0]  = req;
    end

    assign w_pick = rr_pick(w_req8, r_ptr, N_REQ);

    // Arbitration FSM: grant, load operands, wait, acknowledge.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state  <= ST_IDLE;
            r_ptr    <= IDX_W'(N_REQ - 1);
            r_win    <= '0;
            r_gnt    <= '0;
            r_ack    <= '0;
            r_result <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_start  <= 1'b0;
        end else begin
            r_start <= 1'b0;
            r_ack   <= '0;
            unique case (r_state)
                ST_IDLE: begin
                    if (|req) begin
                        r_win   <= w_pick;
                        r_gnt   <= N_REQ'(1) << w_pick;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_a     <= a_in[r_win*WIDTH +: WIDTH];
                    r_b     <= b_in[r_win*WIDTH +: WIDTH];
                    r_start <= 1'b1;
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_mul_done) begin
                        r_result <= w_mul_r;
                        r_ack    <= r_gnt;
                        r_ptr    <= r_win;
                        r_gnt    <= '0;
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .start (r_start),
        .a     (r_a),
        .b     (r_b),
        .r     (w_mul_r),
        .done  (w_mul_done)
    );

    assign gnt    = r_gnt;
    assign ack    = r_ack;
    assign result = r_result;
    assign busy   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter: directed scenarios
// plus random traffic against a transaction-level model.
module tb_mul_arbiter;

    localparam int N = 4;
    localparam int W = 16;

    logic           Clk;
    logic           Rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] a_in;
    logic [N*W-1:0] b_in;
    logic [N-1:0]   gnt;
    logic [N-1:0]   ack;
    logic [W-1:0]   result;
    logic           busy;

    mul_arbiter #(
        .N_REQ (N),
        .WIDTH (W)
    ) dut (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .req    (req),
        .a_in   (a_in),
        .b_in   (b_in),
        .gnt    (gnt),
        .ack    (ack),
        .result (result),
        .busy   (busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit in_rst;

    logic [W-1:0] opA [N];
    logic [W-1:0] opB [N];
    bit           sticky [N];

    // transaction model: one operation in flight at most
    bit           m_active;
    int           m_ptr;
    int           m_w;
    int           m_t0;
    int           m_B;
    int           m_next_free;
    logic [W-1:0] m_pend;
    logic [W-1:0] m_last;

    int ack_log [$];
    int ack_cyc [$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int qget(input int q [$], input int i);
        if (i < q.size())
            return q[i];
        return -1;
    endfunction

    task automatic model_reset();
        m_active    = 1'b0;
        m_ptr       = N - 1;
        m_w         = 0;
        m_t0        = -100;
        m_B         = 0;
        m_next_free = 0;
        m_pend      = '0;
        m_last      = '0;
    endtask

    task automatic drive(input int i, input int a, input int b);
        opA[i] = W'(a);
        opB[i] = W'(b);
        a_in[i*W +: W] = opA[i];
        b_in[i*W +: W] = opB[i];
        req[i] = 1'b1;
    endtask

    // Decide what the arbiter does at the coming edge.
    task automatic model_arb();
        bit found;
        int j;
        found = 1'b0;
        if (!in_rst && (cyc + 1) >= m_next_free && req != '0) begin
            for (int k = 1; k <= N; k++) begin
                j = (m_ptr + k) % N;
                if (!found && req[j]) begin
                    found = 1'b1;
                    m_w   = j;
                end
            end
            m_active    = 1'b1;
            m_t0        = cyc + 1;
            m_B         = int'(opB[m_w]);
            m_pend      = W'((longint'(opA[m_w]) * longint'(opB[m_w])) % 65536);
            m_next_free = m_t0 + m_B + 5;
            m_ptr       = m_w;
        end
    endtask

    task automatic cyc_step();
        logic [N-1:0] eg;
        logic [N-1:0] ea;
        logic         eb;
        model_arb();
        @(posedge Clk);
        cyc++;
        @(negedge Clk);
        eg = '0;
        ea = '0;
        eb = 1'b0;
        if (m_active) begin
            if (cyc >= m_t0 && cyc <= m_t0 + m_B + 2)
                eg = N'(1) << m_w;
            if (cyc == m_t0 + m_B + 3) begin
                ea     = N'(1) << m_w;
                m_last = m_pend;
            end
            eb = (cyc >= m_t0 && cyc <= m_t0 + m_B + 3);
        end
        chk("gnt", gnt, eg);
        chk("ack", ack, ea);
        chk("busy", busy, eb);
        chk("result", result, m_last);
        for (int i = 0; i < N; i++) begin
            if (ack[i] === 1'b1) begin
                ack_log.push_back(i);
                ack_cyc.push_back(cyc);
                if (!sticky[i])
                    req[i] = 1'b0;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++)
            cyc_step();
    endtask

    task automatic do_reset();
        in_rst = 1'b1;
        Rst_n  = 1'b0;
        req    = '0;
        model_reset();
        run(2);
        Rst_n  = 1'b1;
        in_rst = 1'b0;
    endtask

    initial begin
        int t0;
        int guard;
        Rst_n  = 1'b0;
        in_rst = 1'b1;
        req    = '0;
        a_in   = '0;
        b_in   = '0;
        for (int i = 0; i < N; i++) begin
            opA[i]    = '0;
            opB[i]    = '0;
            sticky[i] = 1'b0;
        end
        model_reset();
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_ack", ack, 0);
        chk("rst_result", result, 0);
        chk("rst_busy", busy, 0);
        do_reset();

        // single request A=3 B=5
        ack_cyc.delete();
        drive(0, 3, 5);
        cyc_step();
        t0 = cyc;
        run(11);
        chk("single_lat", qget(ack_cyc, 0) - t0, 8);
        chk("single_res", result, 15);

        // zero multiplier
        ack_cyc.delete();
        drive(2, 9, 0);
        cyc_step();
        t0 = cyc;
        run(6);
        chk("zero_lat", qget(ack_cyc, 0) - t0, 3);
        chk("zero_res", result, 0);

        // all four after reset, B=2
        do_reset();
        ack_log.delete();
        ack_cyc.delete();
        for (int i = 0; i < N; i++)
            drive(i, i + 1, 2);
        run(34);
        for (int i = 0; i < N; i++)
            chk("all4_order", qget(ack_log, i), i);
        for (int i = 0; i < N - 1; i++)
            chk("all4_space", qget(ack_cyc, i + 1) - qget(ack_cyc, i), 7);
        chk("all4_res", result, 8);

        // wrap-around: 3 done, then 1 and 3 together
        drive(3, 2, 1);
        run(8);
        ack_log.delete();
        drive(1, 11, 3);
        drive(3, 13, 2);
        run(20);
        chk("wrap_first", qget(ack_log, 0), 1);
        chk("wrap_second", qget(ack_log, 1), 3);

        // requester 3 keeps req high through DONE
        ack_log.delete();
        sticky[3] = 1'b1;
        drive(3, 5, 1);
        run(3);
        drive(1, 6, 2);
        run(24);
        sticky[3] = 1'b0;
        run(12);
        chk("nostarve_0", qget(ack_log, 0), 3);
        chk("nostarve_1", qget(ack_log, 1), 1);
        chk("nostarve_req", req, 0);

        // overflow
        ack_cyc.delete();
        drive(0, 300, 300);
        cyc_step();
        t0 = cyc;
        run(306);
        chk("ovf_lat", qget(ack_cyc, 0) - t0, 303);
        chk("ovf_res", result, 24464);

        // reset in the middle of RUN
        drive(0, 5, 10);
        cyc_step();
        run(3);
        Rst_n  = 1'b0;
        in_rst = 1'b1;
        req    = '0;
        #1;
        chk("mrst_gnt", gnt, 0);
        chk("mrst_ack", ack, 0);
        chk("mrst_result", result, 0);
        chk("mrst_busy", busy, 0);
        model_reset();
        ack_log.delete();
        run(3);
        chk("mrst_noack", ack_log.size(), 0);
        drive(1, 7, 2);
        drive(2, 4, 3);
        Rst_n  = 1'b1;
        in_rst = 1'b0;
        run(25);
        chk("mrst_first", qget(ack_log, 0), 1);
        chk("mrst_second", qget(ack_log, 1), 2);

        // random traffic
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 7) == 0)
                    drive(i, int'($urandom_range(0, 65535)),
                          int'($urandom_range(0, 6)));
            end
            cyc_step();
        end
        guard = 0;
        while ((req != '0 || cyc < m_next_free) && guard < 400) begin
            cyc_step();
            guard++;
        end
        chk("drain_req", req, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
